// File: rtl/adc_sequencer_pkg.sv
// adc_sequencer_pkg
//   Shared definitions for the ADC channel sequencer: Wishbone register map,
//   sequencer FSM state encoding and a saturating counter helper.
package adc_sequencer_pkg;

    // Wishbone register addresses (word addresses on wb_adr_i)
    localparam logic [15:0] REG_CTRL     = 16'd0;
    localparam logic [15:0] REG_MASK_LO  = 16'd1;
    localparam logic [15:0] REG_MASK_HI  = 16'd2;
    localparam logic [15:0] REG_SETTLE   = 16'd3;
    localparam logic [15:0] REG_INTERVAL = 16'd4;
    localparam logic [15:0] REG_SWEEPS   = 16'd5;
    localparam logic [15:0] REG_TOERR    = 16'd6;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_START   = 3'd2,
        ST_CONVERT = 3'd3,
        ST_EMIT    = 3'd4,
        ST_NEXT    = 3'd5,
        ST_GAP     = 3'd6
    } seq_state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/adc_sequencer_if.sv
// adc_sequencer_if
//   Wishbone classic slave bus used to program the ADC sequencer.
//   Signals:
//     wb_cyc_i / wb_stb_i / wb_we_i : cycle, strobe, write enable (master -> slave)
//     wb_adr_i [15:0]                : register address
//     wb_dat_i [15:0]                : write data
//     wb_dat_o [15:0]                : read data (slave -> master)
//     wb_ack_o                       : single-cycle acknowledge
interface adc_sequencer_if;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [15:0] wb_adr_i;
    logic [15:0] wb_dat_i;
    logic [15:0] wb_dat_o;
    logic        wb_ack_o;

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
        output wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/prio_next_chan.sv
// prio_next_chan
//   Combinational search for the next enabled channel strictly above the
//   current one.
//   Ports:
//     mask    [31:0] in  : channel enable mask
//     ch      [4:0]  in  : current channel
//     next_ch [4:0]  out : lowest set bit of mask above ch (0 when none)
//     found          out : a higher set bit exists
module prio_next_chan (
    input  logic [31:0] mask,
    input  logic [4:0]  ch,
    output logic [4:0]  next_ch,
    output logic        found
);

    logic [31:0] above;

    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_above
            assign above[gi] = mask[gi] & (5'(gi) > ch);
        end
    endgenerate

    // Scan downward so the lowest qualifying bit is the last one written.
    always_comb begin
        next_ch = 5'd0;
        found   = 1'b0;
        for (int i = 31; i >= 0; i--) begin
            if (above[i]) begin
                next_ch = 5'(i);
                found   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adc_sequencer.sv
// adc_sequencer
//   Sweeps the monitor ADC over the enabled channels in ascending order and
//   emits one {adc_result, adc_channel, adc_strb} sample per channel per sweep.
//   Ports:
//     wb_clk_i, wb_rst_i : clock, synchronous active-high reset
//     wb                 : Wishbone slave (CTRL, MASK_LO/HI, SETTLE, INTERVAL,
//                          SWEEPS ro, TOERR ro / write-to-clear)
//     adc_chmux          : analogue mux select
//     adc_start          : one-cycle conversion start
//     adc_data_valid     : conversion done pulse, adc_data qualified by it
//     adc_result, adc_channel, adc_strb : sample stream to value storage
module adc_sequencer
    import adc_sequencer_pkg::*;
#(
    parameter logic [15:0] SETTLE_DEF   = 16'd64,
    parameter logic [15:0] INTERVAL_DEF = 16'd0,
    parameter logic [15:0] TIMEOUT      = 16'd4096
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    adc_sequencer_if.slave       wb,
    output logic [4:0]           adc_chmux,
    output logic                 adc_start,
    input  logic                 adc_data_valid,
    input  logic [11:0]          adc_data,
    output logic [11:0]          adc_result,
    output logic [4:0]           adc_channel,
    output logic                 adc_strb
);

    // Register file
    logic        ack_reg;
    logic [15:0] dat_o_reg;
    logic        ctrl_en_reg;
    logic [31:0] mask_reg;
    logic [15:0] settle_reg;
    logic [15:0] interval_reg;
    logic [15:0] sweeps_reg;
    logic [15:0] toerr_reg;
    logic [15:0] rd_data;
    logic        wb_req;
    logic        wb_wr;

    // Sequencer
    seq_state_t  state_reg, state_next;
    logic [4:0]  ch_reg, ch_next;
    logic [31:0] shadow_reg, shadow_next;
    logic [15:0] cnt_reg, cnt_next;
    logic [11:0] sample_reg, sample_next;
    logic [4:0]  chmux_reg;
    logic        strb_reg;
    logic [11:0] result_reg;
    logic [4:0]  channel_reg;
    logic        sweep_done;
    logic        timeout_hit;
    logic        emit_fire;

    // Channel search: first channel of a freshly latched mask, and the
    // successor of the current channel within the sweep's shadow mask.
    logic [4:0]  low_above0;
    logic        low_found_unused;
    logic [4:0]  first_ch;
    logic [4:0]  succ_ch;
    logic        succ_found;

    prio_next_chan u_first (
        .mask    (mask_reg),
        .ch      (5'd0),
        .next_ch (low_above0),
        .found   (low_found_unused)
    );

    prio_next_chan u_succ (
        .mask    (shadow_reg),
        .ch      (ch_reg),
        .next_ch (succ_ch),
        .found   (succ_found)
    );

    // Bit 0 is not covered by the "strictly above" search.
    assign first_ch = mask_reg[0] ? 5'd0 : low_above0;

    // ------------------------------------------------------------------
    // Wishbone slave
    // ------------------------------------------------------------------
    assign wb_req      = wb.wb_cyc_i & wb.wb_stb_i & ~ack_reg;
    assign wb_wr       = wb_req & wb.wb_we_i;
    assign wb.wb_ack_o = ack_reg;
    assign wb.wb_dat_o = dat_o_reg;

    always_comb begin
        rd_data = 16'h0000;
        case (wb.wb_adr_i)
            REG_CTRL:     rd_data = {15'd0, ctrl_en_reg};
            REG_MASK_LO:  rd_data = mask_reg[15:0];
            REG_MASK_HI:  rd_data = mask_reg[31:16];
            REG_SETTLE:   rd_data = settle_reg;
            REG_INTERVAL: rd_data = interval_reg;
            REG_SWEEPS:   rd_data = sweeps_reg;
            REG_TOERR:    rd_data = toerr_reg;
            default:      rd_data = 16'h0000;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_reg      <= 1'b0;
            dat_o_reg    <= 16'h0000;
            ctrl_en_reg  <= 1'b0;
            mask_reg     <= 32'hFFFF_FFFF;
            settle_reg   <= SETTLE_DEF;
            interval_reg <= INTERVAL_DEF;
            sweeps_reg   <= 16'h0000;
            toerr_reg    <= 16'h0000;
        end else begin
            ack_reg <= wb_req;
            if (wb_req && !wb.wb_we_i) begin
                dat_o_reg <= rd_data;
            end
            if (wb_wr) begin
                case (wb.wb_adr_i)
                    REG_CTRL:     ctrl_en_reg       <= wb.wb_dat_i[0];
                    REG_MASK_LO:  mask_reg[15:0]    <= wb.wb_dat_i;
                    REG_MASK_HI:  mask_reg[31:16]   <= wb.wb_dat_i;
                    REG_SETTLE:   settle_reg        <= wb.wb_dat_i;
                    REG_INTERVAL: interval_reg      <= wb.wb_dat_i;
                    default:      ;
                endcase
            end
            if (sweep_done) begin
                sweeps_reg <= sweeps_reg + 16'd1;
            end
            // A software clear wins over a simultaneous timeout.
            if (wb_wr && (wb.wb_adr_i == REG_TOERR)) begin
                toerr_reg <= 16'h0000;
            end else if (timeout_hit) begin
                toerr_reg <= sat_inc16(toerr_reg);
            end
        end
    end

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_reg   <= ST_IDLE;
            ch_reg      <= 5'd0;
            shadow_reg  <= 32'h0;
            cnt_reg     <= 16'h0000;
            sample_reg  <= 12'h000;
            chmux_reg   <= 5'd0;
            strb_reg    <= 1'b0;
            result_reg  <= 12'h000;
            channel_reg <= 5'd0;
        end else begin
            state_reg  <= state_next;
            ch_reg     <= ch_next;
            shadow_reg <= shadow_next;
            cnt_reg    <= cnt_next;
            sample_reg <= sample_next;
            strb_reg   <= emit_fire;
            if (state_next == ST_SETTLE) begin
                chmux_reg <= ch_next;
            end
            if (emit_fire) begin
                result_reg  <= sample_reg;
                channel_reg <= ch_reg;
            end
        end
    end

    always_comb begin
        state_next  = state_reg;
        ch_next     = ch_reg;
        shadow_next = shadow_reg;
        cnt_next    = cnt_reg;
        sample_next = sample_reg;
        sweep_done  = 1'b0;
        timeout_hit = 1'b0;
        emit_fire   = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (ctrl_en_reg && (mask_reg != 32'h0)) begin
                    shadow_next = mask_reg;
                    ch_next     = first_ch;
                    cnt_next    = 16'h0000;
                    state_next  = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                // A settle setting of 0 still spends one cycle here.
                if (({1'b0, cnt_reg} + 17'd1) >= {1'b0, settle_reg}) begin
                    cnt_next   = 16'h0000;
                    state_next = ST_START;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            ST_START: begin
                cnt_next   = 16'h0000;
                state_next = ST_CONVERT;
            end
            ST_CONVERT: begin
                if (adc_data_valid) begin
                    sample_next = adc_data;
                    state_next  = ST_EMIT;
                end else if (cnt_reg >= (TIMEOUT - 16'd1)) begin
                    // Still emit a sample so the consumer never loses a channel.
                    sample_next = 12'hFFF;
                    timeout_hit = 1'b1;
                    state_next  = ST_EMIT;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            ST_EMIT: begin
                emit_fire  = 1'b1;
                state_next = ST_NEXT;
            end
            ST_NEXT: begin
                cnt_next = 16'h0000;
                if (succ_found) begin
                    ch_next    = succ_ch;
                    state_next = ST_SETTLE;
                end else begin
                    sweep_done = 1'b1;
                    state_next = ST_GAP;
                end
            end
            ST_GAP: begin
                if (cnt_reg >= interval_reg) begin
                    cnt_next = 16'h0000;
                    if (mask_reg != 32'h0) begin
                        shadow_next = mask_reg;
                        ch_next     = first_ch;
                        state_next  = ST_SETTLE;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Disabling aborts from any state; an in-flight sample is dropped.
        if (!ctrl_en_reg) begin
            state_next  = ST_IDLE;
            sweep_done  = 1'b0;
            timeout_hit = 1'b0;
            emit_fire   = 1'b0;
        end
    end

    assign adc_start   = (state_reg == ST_START);
    assign adc_chmux   = chmux_reg;
    assign adc_strb    = strb_reg;
    assign adc_result  = result_reg;
    assign adc_channel = channel_reg;

endmodule
